// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with pixel enable, scaling and output delay
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int SCALE_SHIFT = 1,
  parameter int CNT_W       = 10,
  parameter int PIPE_DLY    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_en,
  output logic [CNT_W-1:0]         x_cnt,
  output logic [CNT_W-1:0]         y_cnt,
  output logic [CNT_W-SCALE_SHIFT-1:0] pixel_x,
  output logic [CNT_W-SCALE_SHIFT-1:0] pixel_y,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     comp_sync,
  output logic                     blank,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HP = (HSYNC_POL != 0);
  localparam logic VP = (VSYNC_POL != 0);

  generate
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
        H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        SCALE_SHIFT < 0 || SCALE_SHIFT > 3 || PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_param
      $error("vga_timing_gen: illegal parameter combination");
    end
  endgenerate

  // Decoded timing flags are stored active-high so a zeroed stage means "blanked, no sync, no marker".
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic ls;
    logic fs;
  } dec_t;

  logic [CNT_W-1:0] x_nxt, y_nxt;
  dec_t cur, outv;

  always_comb begin
    x_nxt = x_cnt;
    y_nxt = y_cnt;
    if (pix_en) begin
      if (x_cnt == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_cnt == V_LAST) ? '0 : y_cnt + CNT_W'(1);
      end else begin
        x_nxt = x_cnt + CNT_W'(1);
      end
    end
  end

  // pixel_x/y are loaded from the next counter values so they stay aligned with x_cnt/y_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      x_cnt   <= x_nxt;
      y_cnt   <= y_nxt;
      pixel_x <= x_nxt[CNT_W-1:SCALE_SHIFT];
      pixel_y <= y_nxt[CNT_W-1:SCALE_SHIFT];
    end
  end

  always_comb begin
    cur     = '0;
    cur.vis = (x_cnt < H_VIS) && (y_cnt < V_VIS);
    cur.hs  = (x_cnt >= H_SS) && (x_cnt < H_SE);
    cur.vs  = (y_cnt >= V_SS) && (y_cnt < V_SE);
    cur.ls  = (x_cnt == '0);
    cur.fs  = (x_cnt == '0) && (y_cnt == '0);
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign outv = cur;
    end else begin : g_dly
      dec_t stage [PIPE_DLY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) stage[i] <= '0;
        end else if (pix_en) begin
          stage[0] <= cur;
          for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
        end
      end
      assign outv = stage[PIPE_DLY-1];
    end
  endgenerate

  assign hsync       = outv.hs ^ ~HP;
  assign vsync       = outv.vs ^ ~VP;
  assign comp_sync   = (outv.hs ^ outv.vs) ^ ~HP;
  assign blank       = outv.vis;
  assign line_start  = outv.ls;
  assign frame_start = outv.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen across three timing modes
module tb_vga_timing_gen;

  typedef struct {
    int x, y, px, py, hsync, vsync, csync, blank, ls, fs;
  } exp_t;

  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  always #5 clk = ~clk;

  logic [9:0] x0, y0;
  logic [8:0] px0, py0;
  logic hs0, vs0, cs0, bl0, ls0, fs0;
  logic [3:0] x1, y1, px1, py1;
  logic hs1, vs1, cs1, bl1, ls1, fs1;
  logic [5:0] x2, y2;
  logic [3:0] px2, py2;
  logic hs2, vs2, cs2, bl2, ls2, fs2;

  vga_timing_gen d0 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x_cnt(x0), .y_cnt(y0),
    .pixel_x(px0), .pixel_y(py0), .hsync(hs0), .vsync(vs0), .comp_sync(cs0),
    .blank(bl0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SCALE_SHIFT(0), .CNT_W(4)
  ) d1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x_cnt(x1), .y_cnt(y1),
    .pixel_x(px1), .pixel_y(py1), .hsync(hs1), .vsync(vs1), .comp_sync(cs1),
    .blank(bl1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1), .VSYNC_POL(1), .SCALE_SHIFT(2), .CNT_W(6), .PIPE_DLY(2)
  ) d2 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .x_cnt(x2), .y_cnt(y2),
    .pixel_x(px2), .pixel_y(py2), .hsync(hs2), .vsync(vs2), .comp_sync(cs2),
    .blank(bl2), .line_start(ls2), .frame_start(fs2));

  exp_t q0[$], q1[$], q2[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit done = 0;

  // Reference: t = enabled edges since reset; position follows from division, delay from t - dly.
  function automatic exp_t model(int t, int ha, int hf, int hs, int hb, int va, int vf, int vs,
                                 int vb, int hp, int vp, int sh, int dly);
    exp_t e;
    int htot = ha + hf + hs + hb;
    int vtot = va + vf + vs + vb;
    int dx, dy, td;
    bit ha_on, va_on;
    e.x  = t % htot;
    e.y  = (t / htot) % vtot;
    e.px = e.x >> sh;
    e.py = e.y >> sh;
    if (t < dly) begin
      e.hsync = 1 - hp; e.vsync = 1 - vp; e.csync = 1 - hp;
      e.blank = 0; e.ls = 0; e.fs = 0;
    end else begin
      td = t - dly;
      dx = td % htot;
      dy = (td / htot) % vtot;
      ha_on = (dx >= ha + hf) && (dx < ha + hf + hs);
      va_on = (dy >= va + vf) && (dy < va + vf + vs);
      e.hsync = ha_on ? hp : 1 - hp;
      e.vsync = va_on ? vp : 1 - vp;
      e.csync = (ha_on != va_on) ? hp : 1 - hp;
      e.blank = (dx < ha && dy < va) ? 1 : 0;
      e.ls = (dx == 0) ? 1 : 0;
      e.fs = (dx == 0 && dy == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic cmp(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, req);
    end
  endtask

  task automatic check_all(string pre, exp_t a, exp_t e);
    cmp({pre, ".x_cnt"}, a.x, e.x);
    cmp({pre, ".y_cnt"}, a.y, e.y);
    cmp({pre, ".pixel_x"}, a.px, e.px);
    cmp({pre, ".pixel_y"}, a.py, e.py);
    cmp({pre, ".hsync"}, a.hsync, e.hsync);
    cmp({pre, ".vsync"}, a.vsync, e.vsync);
    cmp({pre, ".comp_sync"}, a.csync, e.csync);
    cmp({pre, ".blank"}, a.blank, e.blank);
    cmp({pre, ".line_start"}, a.ls, e.ls);
    cmp({pre, ".frame_start"}, a.fs, e.fs);
  endtask

  // Stimulus: choose inputs, let the edge happen, then push what each instance must now show.
  initial begin
    int t = 0;
    bit mid_rst_done = 0;
    rst = 1'b1;
    pix_en = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if (c < 3) begin
        rst = 1'b1;
        pix_en = c[0];
      end else if (c < 1800) begin
        pix_en = 1'b1;
        rst = (!mid_rst_done && t == 1100);
        if (rst) mid_rst_done = 1;
      end else if (c < 3600) begin
        rst = 1'b0;
        pix_en = c[0];
      end else begin
        pix_en = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 699) == 0);
      end
      @(posedge clk);
      #1;
      if (rst) t = 0;
      else if (pix_en) t++;
      q0.push_back(model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 0));
      q1.push_back(model(t, 8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 0, 0));
      q2.push_back(model(t, 20, 3, 4, 5, 10, 2, 2, 3, 1, 1, 2, 2));
    end
    done = 1;
  end

  // Monitor: sample mid-cycle and retire one expectation per instance.
  initial begin
    exp_t a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        a = '{int'(x0), int'(y0), int'(px0), int'(py0), int'(hs0), int'(vs0), int'(cs0),
              int'(bl0), int'(ls0), int'(fs0)};
        check_all("d0", a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a = '{int'(x1), int'(y1), int'(px1), int'(py1), int'(hs1), int'(vs1), int'(cs1),
              int'(bl1), int'(ls1), int'(fs1)};
        check_all("d1", a, q1.pop_front());
      end
      if (q2.size() > 0) begin
        a = '{int'(x2), int'(y2), int'(px2), int'(py2), int'(hs2), int'(vs2), int'(cs2),
              int'(bl2), int'(ls2), int'(fs2)};
        check_all("d2", a, q2.pop_front());
      end
    end
  end

  initial begin
    wait (done);
    repeat (2) @(negedge clk);
    #1;
    cmp("queue_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing counter.
- Generates horizontal/vertical position counters, sync, blanking and frame/line markers for any mode defined by parameters.
- Adds pixel-clock enable, selectable sync polarity, power-of-two pixel down-scaling, and a programmable output delay that aligns sync/blank with downstream pixel-fetch latency.
- Sits between the system clock domain and the video DAC/pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- SCALE_SHIFT, 1, pixel_x/pixel_y = counter >> SCALE_SHIFT (0..3)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PIPE_DLY, 0, delay in enabled cycles applied to blank/syncs/markers (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-rate enable; all state advances only when high
- x_cnt  out  CNT_W  raw horizontal position
- y_cnt  out  CNT_W  raw vertical position
- pixel_x  out  CNT_W-SCALE_SHIFT  scaled horizontal position
- pixel_y  out  CNT_W-SCALE_SHIFT  scaled vertical position
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- comp_sync  out  1  composite sync, polarity HSYNC_POL
- blank  out  1  1 = visible region, 0 = blanked (active-low blanking to DAC)
- line_start  out  1  high while timing position has x = 0
- frame_start  out  1  high while timing position is (0,0)

Behaviour:
- Reset and clock:
  - One clock; reset is synchronous and active-high on rst.
  - rst has priority over pix_en.
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters (registered):
  - On a clk edge with pix_en=1: x_cnt increments, wrapping H_TOTAL-1 -> 0.
  - y_cnt increments only when x_cnt wraps, wrapping V_TOTAL-1 -> 0.
  - pix_en=0: all registers hold.
- pixel_x/pixel_y:
  - Registered from the next counter values, so they always equal x_cnt>>SCALE_SHIFT and y_cnt>>SCALE_SHIFT in the same cycle (zero relative latency).
  - Not clamped in blanking.
- Decode of position (x,y):
  - vis = x<H_ACTIVE and y<V_ACTIVE.
  - hs_act = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
- Output levels:
  - hsync = hs_act ? HSYNC_POL : ~HSYNC_POL.
  - vsync likewise with VSYNC_POL.
  - comp_sync active (HSYNC_POL level) when hs_act XOR vs_act (serrated composite).
  - blank = vis; line_start = (x==0); frame_start = (x==0 and y==0).
- Delay:
  - PIPE_DLY=0: decoded outputs correspond to the current x_cnt/y_cnt.
  - PIPE_DLY=N: they correspond to the position N enabled cycles earlier, via an N-stage shift register advancing only on pix_en.
  - Counters and pixel_x/pixel_y are never delayed.
- Reset values:
  - x_cnt=y_cnt=pixel_x=pixel_y=0.
  - PIPE_DLY=0: outputs equal decode of (0,0): blank=1, line_start=1, frame_start=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, comp_sync=~HSYNC_POL.
  - PIPE_DLY>0: all delay stages reset to blank=0, markers 0, syncs inactive.
- Reset mid-frame: on the edge with rst=1, all state returns to the reset values immediately; counting resumes from (0,0) on the first enabled edge after rst falls.
- Simultaneous x and y wrap (x=H_TOTAL-1, y=V_TOTAL-1, pix_en=1) -> next (0,0).
- Parameter sanity: elaboration error if H_TOTAL > 2^CNT_W, V_TOTAL > 2^CNT_W, or any porch/sync parameter is 0.

Test Plan:
- Defaults, pix_en=1 constant, 2 frames -> line period 800 clk; hsync low exactly x=656..751; vsync low exactly y=490..491; blank=1 only for x<640,y<480; frame period 420000 clk.
- pix_en asserted 1 cycle in 2 -> all periods exactly double; outputs hold on pix_en=0 cycles; pixel_x increments once per 4 clk at SCALE_SHIFT=1.
- Small mode H=8/2/2/2, V=4/1/1/1, SCALE_SHIFT=0 -> x wraps 13->0, y wraps 6->0 on the same edge x wraps; frame_start high only at (0,0).
- rst pulsed at x=300,y=200 -> next cycle x_cnt=y_cnt=0, pixel_x=0, blank=1; counting resumes correctly after release.
- PIPE_DLY=2 -> blank/hsync edges lag the corresponding x_cnt transitions by exactly 2 enabled cycles; first 2 cycles after reset show blank=0.
- HSYNC_POL=1, VSYNC_POL=1 -> syncs high only inside pulse windows; comp_sync high when exactly one of hs_act/vs_act is active.
